wb_trace_fifo: RTL

Register-writeback trace buffer that sits directly downstream of the single-cycle `CPU` core's writeback path. Every cycle in which the core commits a register write, it captures {cycle stamp, PC, destination register, write data} into a FIFO. The bench or a host-side checker drains the FIFO through a valid/ready port. Captures that find the buffer full are dropped, counted, and flagged, so a long program run never stalls the core.

---
 rtl/wb_trace_fifo.sv | 108 ++++++++++
 1 files changed

// File: rtl/wb_trace_fifo.sv
// Register-writeback trace buffer: captures {cycle, pc, rd, data} for every
// committed register write and drains it through a valid/ready port.
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wb_en,
  input  logic [31:0]   wb_pc,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  output logic          tr_valid,
  input  logic          tr_ready,
  output logic [31:0]   tr_cycle,
  output logic [31:0]   tr_pc,
  output logic [4:0]    tr_addr,
  output logic [31:0]   tr_data,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_count
);

  // Handshake: an entry moves when tr_valid && tr_ready at a rising edge.
  // tr_valid is derived from registered occupancy only, never from tr_ready.

  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          new_entry;
  logic [31:0]     cycle_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            cap_req;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // Writes to $zero carry no information and are silently ignored.
  assign cap_req = wb_en && (wb_addr != 5'd0);
  assign full    = (count == FULL_COUNT);
  assign pop     = tr_valid && tr_ready && !clear;
  assign push    = cap_req && !clear && (!full || tr_ready);
  assign drop    = cap_req && !clear && full && !tr_ready;

  assign new_entry = '{cycle: cycle_cnt, pc: wb_pc, addr: wb_addr, data: wb_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Storage needs no reset: the read side masks it whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign tr_valid = (count != '0);

  always_comb begin
    head = '0;
    if (tr_valid) head = mem[rd_ptr];
  end

  assign tr_cycle = head.cycle;
  assign tr_pc    = head.pc;
  assign tr_addr  = head.addr;
  assign tr_data  = head.data;

endmodule
